// File: rtl/program_loader_if.sv
// Length-prefixed instruction stream handshake between the image source and program_loader.
interface program_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Boot loader: writes a length-prefixed image into instruction memory, then releases the CPU.
// Define CHECKSUM_EN to require a trailing mod-2^12 checksum word after the instructions.
module program_loader #(
   parameter int DEPTH = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            restart,
   program_loader_if.slave in_if,
   output logic            imem_we,
   output logic [11:0]     imem_addr,
   output logic [11:0]     imem_wdata,
   output logic            cpu_reset,
   output logic            done,
   output logic            error
);

   localparam logic [2:0] ST_LEN  = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
`ifdef CHECKSUM_EN
   localparam logic [2:0] ST_CHK  = 3'd2;
`endif
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   localparam logic [11:0] DEPTH_W = 12'(DEPTH);

   logic [2:0]  state_q, state_d;
   logic [11:0] idx_q, idx_d;
   logic [11:0] cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [11:0] addr_q, addr_d;
   logic [11:0] wdata_q, wdata_d;
   logic        cpu_reset_q, cpu_reset_d;
`ifdef CHECKSUM_EN
   logic [11:0] sum_q, sum_d;
`endif

   logic        accepting;
   logic        xfer;
   logic [11:0] idx_inc;

   always_comb begin
      accepting = (state_q == ST_LEN) || (state_q == ST_LOAD);
`ifdef CHECKSUM_EN
      accepting = accepting || (state_q == ST_CHK);
`endif
   end

   assign in_if.in_ready = !restart && reset && accepting;
   assign xfer           = in_if.in_valid && in_if.in_ready;
   assign idx_inc        = idx_q + 12'd1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_reset_d = cpu_reset_q;
`ifdef CHECKSUM_EN
      sum_d       = sum_q;
`endif
      if (restart) begin
         state_d     = ST_LEN;
         idx_d       = '0;
         cpu_reset_d = 1'b1;
`ifdef CHECKSUM_EN
         sum_d       = '0;
`endif
      end else begin
         // CPU leaves reset one edge after DONE so the final write has committed.
         if (state_q == ST_DONE) begin
            cpu_reset_d = 1'b0;
         end
         case (state_q)
            ST_LEN: begin
               if (xfer) begin
                  if (in_if.in_data == 12'd0 || in_if.in_data > DEPTH_W) begin
                     state_d = ST_ERR;
                  end else begin
                     cnt_d   = in_if.in_data;
                     idx_d   = '0;
                     state_d = ST_LOAD;
`ifdef CHECKSUM_EN
                     sum_d   = '0;
`endif
                  end
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  we_d    = 1'b1;
                  addr_d  = idx_q;
                  wdata_d = in_if.in_data;
                  idx_d   = idx_inc;
`ifdef CHECKSUM_EN
                  sum_d   = sum_q + in_if.in_data;
                  if (idx_inc == cnt_q) state_d = ST_CHK;
`else
                  if (idx_inc == cnt_q) state_d = ST_DONE;
`endif
               end
            end
`ifdef CHECKSUM_EN
            ST_CHK: begin
               if (xfer) begin
                  state_d = (in_if.in_data == sum_q) ? ST_DONE : ST_ERR;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_LEN;
         idx_q       <= '0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_reset_q <= 1'b1;
`ifdef CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
`ifdef CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERR);

endmodule
